el2_exu_bp_upd_q: RTL and testbench
===================================

Name: el2_exu_bp_upd_q

Overview:
- Downstream neighbour of the EXU ALU control stage; consumes its x-stage branch-resolution outputs: predict packet, PC and valid.
- Stages each resolved branch through an x→r pipeline register and applies r-stage kill.
- Buffers committed predictor updates in a small FIFO.
- Drains the FIFO to the IFU BHT/BTB write port through a valid/ready handshake, so a busy predictor port never stalls the pipeline. Updates are hints; overflow drops them and counts the drops.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  top-level clock
- rst_l  in  1  asynchronous active-low reset
- scan_mode  in  1  scan control, passed to clock-gated flops
- enable  in  1  x→r advance enable; when low, the r register holds
- valid_x  in  1  x-stage branch/jal valid, taken from the ALU valid_in
- flush_upper_x  in  1  squashes the x-stage instruction
- flush_lower_r  in  1  master flush; kills x and r contents
- pc_x  in  31  x-stage PC[31:1]
- pp_x  in  el2_predict_pkt_t  predict_p_out from ALU control
- cfg_misp_only  in  1  1 = enqueue only entries with misp=1
- upd_ready  in  1  predictor write port accepts
- upd_valid  out  1  FIFO head valid
- upd_pkt  out  el2_bp_upd_pkt_t  head entry: pc[31:1], hist[1:0], ataken, misp, way, pcall, pret, pja
- drop_pulse  out  1  one-cycle pulse when an eligible entry is lost to a full FIFO
- drop_cnt  out  CNT_W  saturating drop count
- occupancy  out  PTR_W+1  number of valid entries

Behaviour:
- Reset (async, rst_l=0): r_vld=0, wr_ptr=rd_ptr=0, count=0, drop_cnt=0, drop_pulse=0, upd_valid=0, upd_pkt=0. Reset mid-drain discards all entries with no partial handshake.
- x→r register:
  - When enable=1: r_vld ← valid_x & ~flush_upper_x & ~flush_lower_r; r payload ← {pc_x, pp_x fields}.
  - When enable=0: payload holds; r_vld ← r_vld & ~flush_lower_r.
- Push eligibility: elig = r_vld & ~flush_lower_r & (~cfg_misp_only | r_pkt.misp). An entry filtered by cfg_misp_only is not a drop.
- Pop: pop = upd_valid & upd_ready; upd_valid = (count≠0); upd_pkt = mem[rd_ptr], combinational from registers.
- Push acceptance: push = elig & (count<DEPTH | pop). When full, a simultaneous pop frees a slot and the push is accepted in the same cycle.
- Drop: elig & ~push → drop_pulse=1 next cycle; drop_cnt increments and saturates at all-ones.
- Pointers: increment modulo DEPTH; wrap from DEPTH-1 to 0. count ← count + push − pop. occupancy = count.
- Latency: pp_x in cycle N appears at upd_pkt in cycle N+2 when the FIFO is empty and enable=1.
- Ordering: strict FIFO. The predictor port may hold upd_ready low indefinitely; upd_pkt must stay stable while upd_valid=1 and no pop occurs.
- flush_lower_r never clears FIFO entries: they are already committed.
- Simultaneous push & pop at count=0 is impossible: upd_valid=0, so the push lands and pops next cycle at the earliest.

Decomposition:
- el2_bp_upd_pkt_t and the DEPTH default go in the shared el2 package beside el2_predict_pkt_t.
- One sub-module is natural: el2_exu_bp_upd_fifo, a generic sync FIFO with push/pop/count.
- The x→r stage and the drop logic sit in the top module.
- Payload flops are rvdffe, enabled on write for the FIFO and on enable for the r stage.

Test Plan:
- Single branch: valid_x=1, pc_x=31'h40, misp=1, upd_ready=1, FIFO empty → upd_valid=1 exactly 2 cycles later with pc=31'h40; occupancy returns to 0 one cycle after.
- Backpressure fill: upd_ready=0, 5 consecutive branches, DEPTH=4 → occupancy=4; drop_pulse once; drop_cnt=1; upd_pkt holds the first PC.
- Full + simultaneous pop: count=4, upd_ready=1 with an eligible push the same cycle → no drop, count stays 4, head advances to the second entry.
- Flushes: branch in x with flush_upper_x=1 → never enqueued. Branch in r with flush_lower_r=1 → not enqueued, drop_cnt unchanged.
- Filter: cfg_misp_only=1, entries misp=0,1,0 → exactly one entry enqueued; drop_cnt=0.
- Reset mid-drain: occupancy=3, upd_ready=0, assert rst_l=0 asynchronously → upd_valid=0 and occupancy=0 immediately; after release, a new branch arrives with correct latency and pointers restart at 0.

Source files
------------

// File: rtl/el2_exu_bp_upd_q_pkg.sv
// Shared el2 types for the branch-predictor update queue: the ALU predict packet
// and the BHT/BTB update record, plus the default queue depth.
package el2_exu_bp_upd_q_pkg;

   localparam int BP_UPD_DEPTH = 4;

   typedef struct packed {
      logic        misp;
      logic        ataken;
      logic        boffset;
      logic        pc4;
      logic [1:0]  hist;
      logic [11:0] toffset;
      logic        valid;
      logic        pcall;
      logic        pret;
      logic        pja;
      logic        way;
   } el2_predict_pkt_t;

   typedef struct packed {
      logic [31:1] pc;
      logic [1:0]  hist;
      logic        ataken;
      logic        misp;
      logic        way;
      logic        pcall;
      logic        pret;
      logic        pja;
   } el2_bp_upd_pkt_t;

   function automatic el2_bp_upd_pkt_t bp_upd_pack(input logic [31:1] pc,
                                                   input el2_predict_pkt_t pp);
      el2_bp_upd_pkt_t u;
      u.pc     = pc;
      u.hist   = pp.hist;
      u.ataken = pp.ataken;
      u.misp   = pp.misp;
      u.way    = pp.way;
      u.pcall  = pp.pcall;
      u.pret   = pp.pret;
      u.pja    = pp.pja;
      return u;
   endfunction

endpackage

// File: rtl/el2_exu_bp_upd_q_fifo.sv
// Generic synchronous FIFO with push/pop/count; head data is read straight
// from the storage registers so it is stable while nothing pops.
module el2_exu_bp_upd_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int W     = 8
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             scan_mode,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     wdata_i,
   output logic [W-1:0]     rdata_o,
   output logic [PTR_W:0]   count_o,
   output logic             full_o
);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]          count_q;

   // Storage enable follows the gated-clock flop behaviour: scan forces the clock on.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         mem_q <= '0;
      end else if (push_i | scan_mode) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/el2_exu_bp_upd_q.sv
// Stages resolved branches x->r, applies r-stage kill, and queues committed
// predictor updates for the IFU BHT/BTB port; overflow drops and counts.
module el2_exu_bp_upd_q
   import el2_exu_bp_upd_q_pkg::*;
#(
   parameter int DEPTH = BP_UPD_DEPTH,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             scan_mode,
   input  logic             enable,
   input  logic             valid_x,
   input  logic             flush_upper_x,
   input  logic             flush_lower_r,
   input  logic [31:1]      pc_x,
   input  el2_predict_pkt_t pp_x,
   input  logic             cfg_misp_only,
   input  logic             upd_ready,
   output logic             upd_valid,
   output el2_bp_upd_pkt_t  upd_pkt,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [PTR_W:0]   occupancy
);

   logic             r_vld_q, r_vld_d;
   el2_bp_upd_pkt_t  r_pkt_q;
   logic             drop_pulse_q;
   logic [CNT_W-1:0] drop_cnt_q;
   logic             elig, push, pop, drop, full;
   logic [PTR_W:0]   count;
   logic             unused_pp;

   assign unused_pp = ^{pp_x.boffset, pp_x.pc4, pp_x.toffset, pp_x.valid};

   // A stalled r stage keeps its instruction but still honours the master flush.
   assign r_vld_d = enable ? (valid_x & ~flush_upper_x & ~flush_lower_r)
                           : (r_vld_q & ~flush_lower_r);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) r_vld_q <= 1'b0;
      else        r_vld_q <= r_vld_d;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)                   r_pkt_q <= '0;
      else if (enable | scan_mode)  r_pkt_q <= bp_upd_pack(pc_x, pp_x);
   end

   // Filtered entries are not eligible, so they never count as drops.
   assign elig = r_vld_q & ~flush_lower_r & (~cfg_misp_only | r_pkt_q.misp);
   assign pop  = upd_valid & upd_ready;
   assign push = elig & (~full | pop);
   assign drop = elig & ~push;

   el2_exu_bp_upd_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .W     ($bits(el2_bp_upd_pkt_t))
   ) u_fifo (
      .clk       (clk),
      .rst_l     (rst_l),
      .scan_mode (scan_mode),
      .push_i    (push),
      .pop_i     (pop),
      .wdata_i   (r_pkt_q),
      .rdata_o   (upd_pkt),
      .count_o   (count),
      .full_o    (full)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         drop_pulse_q <= drop;
         if (drop && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
   end

   assign upd_valid  = (count != '0);
   assign occupancy  = count;
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_el2_exu_bp_upd_q.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// reference of the x->r stage, filter, FIFO and drop counter.
module tb_el2_exu_bp_upd_q;
   import el2_exu_bp_upd_q_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_l, scan_mode, enable, valid_x, flush_upper_x, flush_lower_r;
   logic [31:1]      pc_x;
   el2_predict_pkt_t pp_x;
   logic             cfg_misp_only, upd_ready;
   logic             upd_valid, drop_pulse;
   el2_bp_upd_pkt_t  upd_pkt;
   logic [CNT_W-1:0] drop_cnt;
   logic [2:0]       occupancy;

   int checks = 0;
   int errors = 0;

   // reference state
   el2_bp_upd_pkt_t m_q[$];
   logic            m_rv;
   el2_bp_upd_pkt_t m_rp;
   logic            m_pulse;
   int              m_cnt;

   always #5 clk = ~clk;

   el2_exu_bp_upd_q dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .scan_mode     (scan_mode),
      .enable        (enable),
      .valid_x       (valid_x),
      .flush_upper_x (flush_upper_x),
      .flush_lower_r (flush_lower_r),
      .pc_x          (pc_x),
      .pp_x          (pp_x),
      .cfg_misp_only (cfg_misp_only),
      .upd_ready     (upd_ready),
      .upd_valid     (upd_valid),
      .upd_pkt       (upd_pkt),
      .drop_pulse    (drop_pulse),
      .drop_cnt      (drop_cnt),
      .occupancy     (occupancy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic el2_bp_upd_pkt_t to_upd(input logic [31:1] pc, input el2_predict_pkt_t pp);
      el2_bp_upd_pkt_t e;
      e = '0;
      e.pc = pc;  e.hist = pp.hist;  e.ataken = pp.ataken;  e.misp = pp.misp;
      e.way = pp.way;  e.pcall = pp.pcall;  e.pret = pp.pret;  e.pja = pp.pja;
      return e;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_rv = 1'b0;  m_rp = '0;  m_pulse = 1'b0;  m_cnt = 0;
   endtask

   task automatic rand_pp(input logic misp);
      logic [31:0] r;
      r = $urandom;
      pp_x = r[$bits(el2_predict_pkt_t)-1:0];
      pp_x.misp = misp;
   endtask

   task automatic branch(input logic v, input logic [31:1] pc, input logic misp);
      valid_x = v;  pc_x = pc;  rand_pp(misp);
   endtask

   // One clock: evaluate the reference from the driven inputs, take the edge,
   // compare every output, then return at the next falling edge for driving.
   task automatic step();
      logic elig, pop, push, n_rv;
      el2_bp_upd_pkt_t n_rp;
      elig = m_rv & ~flush_lower_r & (~cfg_misp_only | m_rp.misp);
      pop  = (m_q.size() != 0) & upd_ready;
      push = elig & ((m_q.size() < DEPTH) | pop);
      n_rv = enable ? (valid_x & ~flush_upper_x & ~flush_lower_r) : (m_rv & ~flush_lower_r);
      n_rp = enable ? to_upd(pc_x, pp_x) : m_rp;
      @(posedge clk);
      #1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(m_rp);
      m_pulse = elig & ~push;
      if (m_pulse && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      m_rv = n_rv;
      m_rp = n_rp;
      chk("occupancy", 64'(occupancy), 64'(m_q.size()));
      chk("upd_valid", 64'(upd_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("upd_pkt", 64'(upd_pkt), 64'(m_q[0]));
      chk("drop_pulse", 64'(drop_pulse), 64'(m_pulse));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
      @(negedge clk);
   endtask

   initial begin
      rst_l = 1'b0;  scan_mode = 1'b0;  enable = 1'b1;  valid_x = 1'b0;
      flush_upper_x = 1'b0;  flush_lower_r = 1'b0;  pc_x = '0;  pp_x = '0;
      cfg_misp_only = 1'b0;  upd_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_upd_valid", 64'(upd_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
      chk("rst_upd_pkt", 64'(upd_pkt), 64'd0);
      @(negedge clk);
      rst_l = 1'b1;

      // single branch: visible two edges after capture, gone one edge later
      upd_ready = 1'b1;
      branch(1'b1, 31'h40, 1'b1);
      step();
      branch(1'b0, 31'h0, 1'b0);
      chk("single_not_yet", 64'(upd_valid), 64'd0);
      step();
      chk("single_valid", 64'(upd_valid), 64'd1);
      chk("single_pc", 64'(upd_pkt.pc), 64'h40);
      step();
      chk("single_drained", 64'(occupancy), 64'd0);

      // misp-only filter: only the middle entry is kept, no drops
      upd_ready = 1'b0;  cfg_misp_only = 1'b1;
      branch(1'b1, 31'h60, 1'b0);  step();
      branch(1'b1, 31'h61, 1'b1);  step();
      branch(1'b1, 31'h62, 1'b0);  step();
      branch(1'b0, 31'h0, 1'b0);   step();  step();
      chk("filter_occ", 64'(occupancy), 64'd1);
      chk("filter_pc", 64'(upd_pkt.pc), 64'h61);
      chk("filter_drops", 64'(drop_cnt), 64'd0);
      cfg_misp_only = 1'b0;  upd_ready = 1'b1;
      step();

      // backpressure: five branches into four slots
      upd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         branch(1'b1, 31'h100 + 31'(i), 1'b1);
         step();
      end
      branch(1'b0, 31'h0, 1'b0);
      step();
      chk("bp_occ", 64'(occupancy), 64'd4);
      chk("bp_pulse", 64'(drop_pulse), 64'd1);
      chk("bp_cnt", 64'(drop_cnt), 64'd1);
      chk("bp_head", 64'(upd_pkt.pc), 64'h100);
      step();
      chk("bp_pulse_once", 64'(drop_pulse), 64'd0);

      // full with simultaneous pop: push accepted, head advances
      branch(1'b1, 31'h200, 1'b1);  step();
      branch(1'b0, 31'h0, 1'b0);  upd_ready = 1'b1;  step();
      chk("fullpop_occ", 64'(occupancy), 64'd4);
      chk("fullpop_cnt", 64'(drop_cnt), 64'd1);
      chk("fullpop_head", 64'(upd_pkt.pc), 64'h101);
      repeat (5) step();

      // flushes: upper kills in x, lower kills in r without counting a drop
      branch(1'b1, 31'h300, 1'b1);  flush_upper_x = 1'b1;  step();
      flush_upper_x = 1'b0;  branch(1'b0, 31'h0, 1'b0);  step();  step();
      chk("flush_upper", 64'(occupancy), 64'd0);
      branch(1'b1, 31'h301, 1'b1);  step();
      branch(1'b0, 31'h0, 1'b0);  flush_lower_r = 1'b1;  step();
      flush_lower_r = 1'b0;  step();
      chk("flush_lower_occ", 64'(occupancy), 64'd0);
      chk("flush_lower_cnt", 64'(drop_cnt), 64'd1);

      // reset mid-drain
      upd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         branch(1'b1, 31'h400 + 31'(i), 1'b1);
         step();
      end
      branch(1'b0, 31'h0, 1'b0);  step();
      chk("pre_rst_occ", 64'(occupancy), 64'd3);
      #2 rst_l = 1'b0;
      #1;
      chk("async_rst_valid", 64'(upd_valid), 64'd0);
      chk("async_rst_occ", 64'(occupancy), 64'd0);
      chk("async_rst_cnt", 64'(drop_cnt), 64'd0);
      model_reset();
      @(negedge clk);
      rst_l = 1'b1;
      upd_ready = 1'b1;
      branch(1'b1, 31'h55, 1'b1);  step();
      branch(1'b0, 31'h0, 1'b0);   step();
      chk("post_rst_valid", 64'(upd_valid), 64'd1);
      chk("post_rst_pc", 64'(upd_pkt.pc), 64'h55);
      step();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 0) cfg_misp_only = ($urandom_range(0, 1) == 1);
         valid_x       = ($urandom_range(0, 99) < 65);
         pc_x          = 31'($urandom);
         rand_pp(($urandom_range(0, 1) == 1));
         enable        = ($urandom_range(0, 99) < 90);
         flush_upper_x = ($urandom_range(0, 99) < 6);
         flush_lower_r = ($urandom_range(0, 99) < 6);
         upd_ready     = ($urandom_range(0, 99) < ((n / 100) % 2 == 0 ? 30 : 70));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
